pipe_hazard_ctrl: RTL and testbench

//  Central stall/flush controller for the 7-stage core (PC, PF, IF, ID, EX, MEM1, MEM2, WB).

---
 rtl/pipe_hazard_ctrl.sv | 124 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 7-stage core: pipeline-register write enables,
// flushes, exception/eret redirect, a pending-icache-fill wait state and perf counters.
module pipe_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             icache_stall,
  input  logic             dcache_stall,
  input  logic             div_busy,
  input  logic             load_use,
  input  logic             MEM1_ex,
  input  logic             MEM1_eret,
  output logic             PC_Wr,
  output logic             PF_IFWr,
  output logic             IF_IDWr,
  output logic             ID_EXWr,
  output logic             EX_MEM1Wr,
  output logic             MEM1_MEM2Wr,
  output logic             MEM2_WBWr,
  output logic             PF_Flush,
  output logic             IF_Flush,
  output logic             ID_Flush,
  output logic             EX_Flush,
  output logic             MEM1_Flush,
  output logic             MEM2_Flush,
  output logic             redirect,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] redir_cnt
);

  localparam logic [0:0] RUN     = 1'b0;
  localparam logic [0:0] WAIT_IC = 1'b1;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [0:0] state;
  logic [0:0] state_nxt;
  logic       stall_inc;
  logic       redir_inc;

  always_comb begin
    // NOTE: every output gets a default before any branch so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    PC_Wr       = 1'b1;
    PF_IFWr     = 1'b1;
    IF_IDWr     = 1'b1;
    ID_EXWr     = 1'b1;
    EX_MEM1Wr   = 1'b1;
    MEM1_MEM2Wr = 1'b1;
    MEM2_WBWr   = 1'b1;
    PF_Flush    = 1'b0;
    IF_Flush    = 1'b0;
    ID_Flush    = 1'b0;
    EX_Flush    = 1'b0;
    MEM1_Flush  = 1'b0;
    MEM2_Flush  = 1'b0;
    redirect    = 1'b0;
    redir_inc   = 1'b0;
    state_nxt   = state;

    if (rst) begin
      {PC_Wr, PF_IFWr, IF_IDWr, ID_EXWr, EX_MEM1Wr, MEM1_MEM2Wr, MEM2_WBWr} = '0;
      {PF_Flush, IF_Flush, ID_Flush, EX_Flush, MEM1_Flush, MEM2_Flush}     = '1;
      state_nxt = RUN;
    end else if (state == RUN) begin
      if (dcache_stall) begin
        // The older MEM2 access must retire before any MEM1 redirect is taken.
        {PC_Wr, PF_IFWr, IF_IDWr, ID_EXWr, EX_MEM1Wr, MEM1_MEM2Wr, MEM2_WBWr} = '0;
        MEM2_Flush = 1'b1;
      end else if (MEM1_ex || MEM1_eret) begin
        redirect   = 1'b1;
        redir_inc  = 1'b1;
        {PF_Flush, IF_Flush, ID_Flush, EX_Flush, MEM1_Flush} = '1;
        if (icache_stall) state_nxt = WAIT_IC;
      end else if (div_busy) begin
        {PC_Wr, PF_IFWr, IF_IDWr, ID_EXWr} = '0;
        EX_Flush = 1'b1;
      end else if (load_use) begin
        {PC_Wr, PF_IFWr, IF_IDWr} = '0;
        ID_Flush = 1'b1;
      end else if (icache_stall) begin
        {PC_Wr, PF_IFWr} = '0;
        IF_Flush = 1'b1;
      end
    end else begin
      // Fill in flight cannot be aborted; its data is discarded through PF/IF flushes,
      // which also stay set in the exit cycle.
      PC_Wr    = 1'b0;
      PF_IFWr  = 1'b0;
      PF_Flush = 1'b1;
      IF_Flush = 1'b1;
      if (dcache_stall) begin
        {IF_IDWr, ID_EXWr, EX_MEM1Wr, MEM1_MEM2Wr, MEM2_WBWr} = '0;
        MEM2_Flush = 1'b1;
      end else if (div_busy) begin
        {IF_IDWr, ID_EXWr} = '0;
        EX_Flush = 1'b1;
      end else if (load_use) begin
        IF_IDWr  = 1'b0;
        ID_Flush = 1'b1;
      end
      if (!icache_stall) state_nxt = RUN;
    end
  end

  assign stall_inc = !rst && (state == RUN) && !PC_Wr;

  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      state     <= RUN;
      stall_cnt <= '0;
      redir_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (stall_inc && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CNT_ONE;
      if (redir_inc && redir_cnt != CNT_MAX) redir_cnt <= redir_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: expected strobes are queued when stimulus is
// driven and popped when outputs settle; counters are checked against a saturating model.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst, icache_stall, dcache_stall, div_busy, load_use, MEM1_ex, MEM1_eret;

  logic       a_pc, a_pf, a_if, a_id, a_ex, a_m1, a_m2;
  logic       a_fpf, a_fif, a_fid, a_fex, a_fm1, a_fm2, a_red;
  logic [3:0] a_stall, a_redir;
  logic       b_pc, b_pf, b_if, b_id, b_ex, b_m1, b_m2;
  logic       b_fpf, b_fif, b_fid, b_fex, b_fm1, b_fm2, b_red;
  logic [31:0] b_stall, b_redir;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.CNT_W(4)) dut_a (
    .clk(clk), .rst(rst), .icache_stall(icache_stall), .dcache_stall(dcache_stall),
    .div_busy(div_busy), .load_use(load_use), .MEM1_ex(MEM1_ex), .MEM1_eret(MEM1_eret),
    .PC_Wr(a_pc), .PF_IFWr(a_pf), .IF_IDWr(a_if), .ID_EXWr(a_id), .EX_MEM1Wr(a_ex),
    .MEM1_MEM2Wr(a_m1), .MEM2_WBWr(a_m2),
    .PF_Flush(a_fpf), .IF_Flush(a_fif), .ID_Flush(a_fid), .EX_Flush(a_fex),
    .MEM1_Flush(a_fm1), .MEM2_Flush(a_fm2), .redirect(a_red),
    .stall_cnt(a_stall), .redir_cnt(a_redir));

  pipe_hazard_ctrl dut_b (
    .clk(clk), .rst(rst), .icache_stall(icache_stall), .dcache_stall(dcache_stall),
    .div_busy(div_busy), .load_use(load_use), .MEM1_ex(MEM1_ex), .MEM1_eret(MEM1_eret),
    .PC_Wr(b_pc), .PF_IFWr(b_pf), .IF_IDWr(b_if), .ID_EXWr(b_id), .EX_MEM1Wr(b_ex),
    .MEM1_MEM2Wr(b_m1), .MEM2_WBWr(b_m2),
    .PF_Flush(b_fpf), .IF_Flush(b_fif), .ID_Flush(b_fid), .EX_Flush(b_fex),
    .MEM1_Flush(b_fm1), .MEM2_Flush(b_fm2), .redirect(b_red),
    .stall_cnt(b_stall), .redir_cnt(b_redir));

  // Input vector: {rst, icache, dcache, div, load_use, ex, eret}
  localparam logic [6:0] I_RST = 7'b1000000, I_IDLE = 7'b0000000, I_IC  = 7'b0100000;
  localparam logic [6:0] I_DC  = 7'b0010000, I_DIV  = 7'b0001000, I_LU  = 7'b0000100;
  localparam logic [6:0] I_EX  = 7'b0000010, I_ERET = 7'b0000001;

  // Expected vector: {wr[6:0] PC..MEM2_WB, flush[5:0] PF..MEM2, redirect}
  localparam logic [13:0] E_RST   = {7'b0000000, 6'b111111, 1'b0};
  localparam logic [13:0] E_IDLE  = {7'b1111111, 6'b000000, 1'b0};
  localparam logic [13:0] E_LU    = {7'b0001111, 6'b001000, 1'b0};
  localparam logic [13:0] E_DC    = {7'b0000000, 6'b000001, 1'b0};
  localparam logic [13:0] E_REDIR = {7'b1111111, 6'b111110, 1'b1};
  localparam logic [13:0] E_DIV   = {7'b0000111, 6'b000100, 1'b0};
  localparam logic [13:0] E_IC    = {7'b0011111, 6'b010000, 1'b0};
  localparam logic [13:0] E_W     = {7'b0011111, 6'b110000, 1'b0};
  localparam logic [13:0] E_W_DC  = {7'b0000000, 6'b110001, 1'b0};
  localparam logic [13:0] E_W_DIV = {7'b0000111, 6'b110100, 1'b0};
  localparam logic [13:0] E_W_LU  = {7'b0001111, 6'b111000, 1'b0};

  int checks = 0;
  int errors = 0;

  logic [13:0] exp_q[$];
  logic [3:0]  m_stall4 = '0, m_redir4 = '0;
  logic [31:0] m_stall32 = '0, m_redir32 = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, compare strobes 1ns later, compare counters after posedge.
  task automatic step(input string tag, input logic [6:0] in, input logic [13:0] exp,
                      input bit cnt_stall, input bit cnt_redir);
    logic [13:0] e;
    @(negedge clk);
    {rst, icache_stall, dcache_stall, div_busy, load_use, MEM1_ex, MEM1_eret} = in;
    exp_q.push_back(exp);
    #1;
    e = exp_q.pop_front();
    check({tag, ".a"}, {18'h0, a_pc, a_pf, a_if, a_id, a_ex, a_m1, a_m2,
                        a_fpf, a_fif, a_fid, a_fex, a_fm1, a_fm2, a_red}, {18'h0, e});
    check({tag, ".b"}, {18'h0, b_pc, b_pf, b_if, b_id, b_ex, b_m1, b_m2,
                        b_fpf, b_fif, b_fid, b_fex, b_fm1, b_fm2, b_red}, {18'h0, e});
    if (in[6]) begin
      m_stall4 = '0; m_redir4 = '0; m_stall32 = '0; m_redir32 = '0;
    end else begin
      if (cnt_stall) begin
        if (m_stall4 != 4'hF) m_stall4 = m_stall4 + 4'd1;
        m_stall32 = m_stall32 + 32'd1;
      end
      if (cnt_redir) begin
        if (m_redir4 != 4'hF) m_redir4 = m_redir4 + 4'd1;
        m_redir32 = m_redir32 + 32'd1;
      end
    end
    @(posedge clk);
    #1;
    check({tag, ".stall4"},  {28'h0, a_stall}, {28'h0, m_stall4});
    check({tag, ".redir4"},  {28'h0, a_redir}, {28'h0, m_redir4});
    check({tag, ".stall32"}, b_stall, m_stall32);
    check({tag, ".redir32"}, b_redir, m_redir32);
  endtask

  initial begin
    {rst, icache_stall, dcache_stall, div_busy, load_use, MEM1_ex, MEM1_eret} = I_RST;

    // T1: reset, then release
    step("t1_rst0", I_RST, E_RST, 0, 0);
    step("t1_rst1", I_RST, E_RST, 0, 0);
    step("t1_run",  I_IDLE, E_IDLE, 0, 0);

    // T2: single load-use bubble
    step("t2_lu",   I_LU, E_LU, 1, 0);
    step("t2_idle", I_IDLE, E_IDLE, 0, 0);

    // T3: dcache stall masks a MEM1 exception until it clears
    step("t3_rst", I_RST, E_RST, 0, 0);
    for (int i = 0; i < 3; i++) step("t3_dc_ex", I_DC | I_EX, E_DC, 1, 0);
    step("t3_redir", I_EX, E_REDIR, 0, 1);
    step("t3_idle",  I_IDLE, E_IDLE, 0, 0);

    // T4: redirect during icache fill enters WAIT_IC; later stages still obey their rows
    step("t4_rst",   I_RST, E_RST, 0, 0);
    step("t4_redir", I_EX | I_IC, E_REDIR, 0, 1);
    step("t4_w0",    I_IC, E_W, 0, 0);
    step("t4_w_dc",  I_IC | I_DC, E_W_DC, 0, 0);
    step("t4_w_div", I_IC | I_DIV, E_W_DIV, 0, 0);
    step("t4_w_lu",  I_IC | I_LU, E_W_LU, 0, 0);
    step("t4_w_ex",  I_IC | I_EX, E_W, 0, 0);
    step("t4_exit",  I_IDLE, E_W, 0, 0);
    step("t4_run",   I_IDLE, E_IDLE, 0, 0);

    // T5: divider busy for 4 cycles
    step("t5_rst", I_RST, E_RST, 0, 0);
    for (int i = 0; i < 4; i++) step("t5_div", I_DIV, E_DIV, 1, 0);
    step("t5_idle", I_IDLE, E_IDLE, 0, 0);

    // T6: saturation of both 4-bit counters (32-bit copy keeps counting exactly)
    step("t6_ic_run", I_IC, E_IC, 1, 0);
    for (int i = 0; i < 8; i++) step("t6_ic_sat", I_IC, E_IC, 1, 0);
    for (int i = 0; i < 3; i++) step("t6_ic_hold", I_IC, E_IC, 1, 0);
    for (int i = 0; i < 17; i++) step("t6_eret_sat", I_ERET, E_REDIR, 0, 1);
    check("t6_stall_sat", {28'h0, a_stall}, 32'hF);
    check("t6_redir_sat", {28'h0, a_redir}, 32'hF);

    // Reset while in WAIT_IC abandons the wait immediately
    step("t6_enter_w", I_ERET | I_IC, E_REDIR, 0, 1);
    step("t6_w",       I_IC, E_W, 0, 0);
    step("t6_rst_w",   I_RST | I_IC, E_RST, 0, 0);
    step("t6_after",   I_IDLE, E_IDLE, 0, 0);
    step("t6_ic_run",  I_IC, E_IC, 1, 0);

    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
